// File: rtl/recir_link_ctrl.sv
// Recirculation select controller: holds the phy_tx recirculation stage active while the
// lane trains on IDLE_WORD, releases it at a word boundary once locked, and falls back on loss.
module recir_link_ctrl #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(32'hBCBC_BCBC),
    parameter int                LOCK_CNT  = 4,
    parameter int                TIMEOUT   = 16,
    parameter int                CNT_W     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              force_recir,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              active,
    output logic              locked,
    output logic              link_lost,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        RECIR     = 2'b00,
        PEND_PASS = 2'b01,
        PASS      = 2'b10,
        ILLEGAL   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CNT - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    state_t           state, state_n;
    logic [CNT_W-1:0] good_cnt, good_n;
    logic [CNT_W-1:0] idle_cnt, idle_n;
    logic             lost_n;
    logic             is_idle;

    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        idle_n  = idle_cnt;
        lost_n  = 1'b0;
        is_idle = valid_in && (data_in == IDLE_WORD);
        if (!enable || force_recir) begin
            state_n = RECIR;
            good_n  = '0;
            idle_n  = '0;
        end else begin
            case (state)
                RECIR: begin
                    idle_n = '0;
                    if (is_idle) begin
                        if (good_cnt >= LOCK_LAST) begin
                            state_n = PEND_PASS;
                            good_n  = '0;
                        end else begin
                            good_n = sat_inc(good_cnt);
                        end
                    end else if (valid_in) begin
                        good_n = '0;
                    end
                end
                // Only switch paths on a gap or an IDLE word so no payload word is split.
                PEND_PASS: begin
                    good_n = '0;
                    if (!valid_in || is_idle) begin
                        state_n = PASS;
                        idle_n  = '0;
                    end
                end
                PASS: begin
                    good_n = '0;
                    if (valid_in) begin
                        idle_n = '0;
                    end else if (idle_cnt >= TO_LAST) begin
                        state_n = RECIR;
                        idle_n  = '0;
                        lost_n  = 1'b1;
                    end else begin
                        idle_n = sat_inc(idle_cnt);
                    end
                end
                default: begin
                    state_n = RECIR;
                    good_n  = '0;
                    idle_n  = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state, so they follow the state register exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RECIR;
            good_cnt  <= '0;
            idle_cnt  <= '0;
            link_lost <= 1'b0;
            active    <= 1'b1;
            locked    <= 1'b0;
            state_o   <= 2'b00;
        end else begin
            state     <= state_n;
            good_cnt  <= good_n;
            idle_cnt  <= idle_n;
            link_lost <= lost_n;
            active    <= (state_n != PASS);
            locked    <= (state_n == PASS);
            state_o   <= state_n;
        end
    end

endmodule
